// File: rtl/reg_share_pkg.sv
// Shared types and helpers for the shared-flop write arbiter.
// Optional write-check logic in the top is selected by ARB_WRITE_CHECK_EN.
package reg_share_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      ACK   = 2'd2
   } state_t;

   localparam int unsigned NUM_REQ_DEFAULT = 4;

   // Round-robin pointer width for a given requester count (never below 1 bit).
   function automatic int unsigned ptr_width(input int unsigned n);
      int unsigned w;
      w = (n < 2) ? 32'd1 : 32'($clog2(n));
      return w;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority encoder: first set req bit at or after ptr.
module rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [PTR_W-1:0]   winner,
   output logic               valid
);

   // ptr + off, wrapped into 0..NUM_REQ-1 (off is always below NUM_REQ).
   function automatic logic [PTR_W-1:0] rot_idx(input logic [PTR_W-1:0] p,
                                                 input int unsigned      off);
      int unsigned s;
      s = 32'(p) + off;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return PTR_W'(s);
   endfunction

   always_comb begin
      winner = '0;
      valid  = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!valid && req[rot_idx(ptr, i)]) begin
            winner = rot_idx(ptr, i);
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter sharing one enabled flop (en/d/q) among NUM_REQ requesters.
// Define ARB_WRITE_CHECK_EN to build the sticky read-back compare on err.
module reg_share_arbiter
   import reg_share_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] wdata,
   input  logic               q_in,
   output logic               en,
   output logic               d,
   output logic [NUM_REQ-1:0] grant,
   output logic [NUM_REQ-1:0] ack,
   output logic               busy,
   output logic               err
);

   localparam int unsigned PTR_W = ptr_width(NUM_REQ);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
   localparam logic [PTR_W-1:0]   LAST_IDX = PTR_W'(NUM_REQ - 1);

   state_t           state;
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] owner;
   logic [PTR_W-1:0] pick_w;
   logic             pick_valid;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick (
      .req    (req),
      .ptr    (ptr),
      .winner (pick_w),
      .valid  (pick_valid)
   );

   // Arbitration FSM; all flop-facing and requester-facing outputs are registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= '0;
         owner <= '0;
         en    <= 1'b0;
         d     <= 1'b0;
         grant <= '0;
         ack   <= '0;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  state <= WRITE;
                  owner <= pick_w;
                  grant <= ONE_HOT0 << pick_w;
                  en    <= 1'b1;
                  d     <= wdata[pick_w];
                  busy  <= 1'b1;
               end
            end
            WRITE: begin
               state <= ACK;
               en    <= 1'b0;
               ack   <= grant;
            end
            ACK: begin
               state <= IDLE;
               ack   <= '0;
               grant <= '0;
               busy  <= 1'b0;
               ptr   <= (owner == LAST_IDX) ? '0 : owner + PTR_W'(1);
            end
            default: begin
               state <= IDLE;
               en    <= 1'b0;
               ack   <= '0;
               grant <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef ARB_WRITE_CHECK_EN
   // q must reflect the written bit by the time the transaction closes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (state == ACK && q_in != d) begin
         err <= 1'b1;
      end
   end
`else
   logic unused_q_in;
   assign unused_q_in = q_in;
   assign err         = 1'b0;
`endif

   a_grant_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
   a_ack_onehot   : assert property (@(posedge clk) disable iff (rst) $onehot0(ack));
   a_ack_subset   : assert property (@(posedge clk) disable iff (rst) (ack & ~grant) == '0);
   a_en_single    : assert property (@(posedge clk) disable iff (rst) en |=> !en);

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Scoreboard bench for reg_share_arbiter: reference model predicts grants, monitor checks.
module tb_reg_share_arbiter;

   localparam int unsigned N = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] req = '0;
   logic [N-1:0] wdata = '0;
   logic         q_in;
   logic         en, d, busy, err;
   logic [N-1:0] grant, ack;

   logic         qflop;
   logic         bad_q = 1'b0;
   int           cyc = 0;
   int           checks = 0;
   int           errors = 0;

   typedef struct {
      int          edge_no;
      int unsigned w;
      logic        data;
   } exp_t;

   exp_t        sb[$];
   int unsigned mptr = 0;
   int          mcnt = 0;

   reg_share_arbiter #(.NUM_REQ(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .wdata (wdata),
      .q_in  (q_in),
      .en    (en),
      .d     (d),
      .grant (grant),
      .ack   (ack),
      .busy  (busy),
      .err   (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // The shared flop itself, with an optional stuck-at-0 fault on its output.
   always @(posedge clk or posedge rst) begin
      if (rst) qflop <= 1'b0;
      else if (en) qflop <= d;
   end
   assign q_in = bad_q ? 1'b0 : qflop;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: a free arbiter grants the first requester at/after the pointer;
   // each transaction occupies three edges before the next decision.
   task automatic model_eval();
      if (mcnt == 0) begin
         if (req != '0) begin
            int unsigned w;
            bit found;
            w = 0;
            found = 0;
            for (int unsigned i = 0; i < N; i++) begin
               if (!found && req[(mptr + i) % N]) begin
                  w = (mptr + i) % N;
                  found = 1;
               end
            end
            sb.push_back('{cyc + 1, w, wdata[w]});
            mptr = (w + 1) % N;
            mcnt = 2;
         end
      end else begin
         mcnt--;
      end
   endtask

   task automatic step(input logic [N-1:0] r, input logic [N-1:0] wd);
      @(negedge clk);
      req   = r;
      wdata = wd;
      model_eval();
   endtask

   // Monitor: checks every cycle against scoreboard entries, independent of stimulus.
   initial begin
      bit           pend;
      logic [N-1:0] pend_grant;
      logic         pend_d;
      bit           prev_en;
      bit           exp_err;
      bit           err_set;
      exp_t         e;
      pend = 0; pend_grant = '0; pend_d = 0; prev_en = 0; exp_err = 0; err_set = 0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            pend = 0; prev_en = 0; exp_err = 0; err_set = 0;
         end else begin
            if (err_set) exp_err = 1;
            err_set = 0;
            chk("err", 32'(err), 32'(exp_err));
            if (en && prev_en) chk("en_back_to_back", 32'(en), 32'(0));
            prev_en = en;
            if (pend) begin
               chk("ack", 32'(ack), 32'(pend_grant));
               chk("ack_grant", 32'(grant), 32'(pend_grant));
               chk("ack_en", 32'(en), 32'(0));
               chk("ack_busy", 32'(busy), 32'(1));
               if (!bad_q) chk("q_in", 32'(q_in), 32'(pend_d));
`ifdef ARB_WRITE_CHECK_EN
               if (q_in !== pend_d) err_set = 1;
`endif
               pend = 0;
            end else begin
               chk("ack_idle", 32'(ack), 32'(0));
               if (en) begin
                  if (sb.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_grant at cycle %0d: got grant %0h expected none", cyc, grant);
                  end else begin
                     e = sb.pop_front();
                     chk("grant_edge", 32'(cyc), 32'(e.edge_no));
                     chk("grant", 32'(grant), 32'(1) << e.w);
                     chk("d", 32'(d), 32'(e.data));
                     chk("busy", 32'(busy), 32'(1));
                     pend       = 1;
                     pend_grant = N'(1) << e.w;
                     pend_d     = e.data;
                  end
               end else begin
                  chk("grant_idle", 32'(grant), 32'(0));
                  chk("busy_idle", 32'(busy), 32'(0));
                  if (sb.size() > 0 && sb[0].edge_no <= cyc) begin
                     checks++;
                     errors++;
                     $display("FAIL missing_grant at cycle %0d: got none expected requester %0d", cyc, sb[0].w);
                     void'(sb.pop_front());
                  end
               end
            end
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_en", 32'(en), 32'(0));
      chk("rst_grant", 32'(grant), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_err", 32'(err), 32'(0));
      rst = 1'b0;

      // Idle: no activity, pointer must stay at 0.
      repeat (10) step('0, '0);

      // All requesting: grants 0,1,2,3,0 every three edges.
      repeat (13) step(4'b1111, 4'($urandom_range(0, 15)));
      repeat (3) step('0, '0);

      // Single write from requester 2.
      step(4'b0100, 4'b0100);
      repeat (4) step('0, '0);

      // Pointer at 3 with requesters 3 and 0: wrap order 3 then 0.
      repeat (6) step(4'b1001, 4'b1001);
      repeat (3) step('0, '0);

      // q forced low across a d=1 write, then a good write.
      bad_q = 1'b1;
      step(4'b0001, 4'b0001);
      repeat (3) step('0, '0);
      bad_q = 1'b0;
      step(4'b0010, 4'b0010);
      repeat (4) step('0, '0);

      // Reset during WRITE: outputs clear immediately, no ack, pointer back to 0.
      step(4'b0100, 4'b0100);
      @(posedge clk);
      #2;
      chk("pre_rst_en", 32'(en), 32'(1));
      rst = 1'b1;
      req = '0;
      #1;
      chk("async_en", 32'(en), 32'(0));
      chk("async_grant", 32'(grant), 32'(0));
      chk("async_busy", 32'(busy), 32'(0));
      chk("async_err", 32'(err), 32'(0));
      sb.delete();
      mptr = 0;
      mcnt = 0;
      repeat (2) @(negedge clk);
      chk("rst_hold_ack", 32'(ack), 32'(0));
      rst = 1'b0;
      repeat (6) step(4'b1001, 4'b0001);
      repeat (3) step('0, '0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         logic [N-1:0] r;
         r = N'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) r = '0;
         step(r, N'($urandom_range(0, 15)));
      end
      repeat (6) step('0, '0);
      chk("scoreboard_empty", 32'(sb.size()), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_share_arbiter.md
Name: reg_share_arbiter

Overview:
- Round-robin write arbiter that shares one enabled D flip-flop (ports en, d, q) among NUM_REQ requesters.
- Each requester posts a one-bit write. The arbiter grants one requester at a time and drives en/d for exactly one cycle.
- It then acknowledges the winner once q reflects the write.
- Sits between requester logic and the shared flop; the flop's q is fed back as q_in.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- PTR_W, $clog2(NUM_REQ), width of the round-robin pointer (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- req  input  NUM_REQ  level request per requester
- wdata  input  NUM_REQ  write bit per requester
- q_in  input  1  q of the shared flop
- en  output  1  enable to the shared flop, registered
- d  output  1  data to the shared flop, registered
- grant  output  NUM_REQ  one-hot owner; zero when idle
- ack  output  NUM_REQ  one-cycle completion pulse to the owner
- busy  output  1  high in WRITE and ACK
- err  output  1  sticky write-check error (see Optional Feature)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, ptr=0.
  - en=0, d=0, grant=0, ack=0, busy=0, err=0.
  - Reset mid-WRITE/ACK aborts the transaction: no ack is issued, and en drops immediately.
- States: IDLE, WRITE, ACK.
- IDLE:
  - If req==0, stay.
  - Otherwise pick winner w = first set req bit scanning ptr, ptr+1, ... mod NUM_REQ.
  - At that edge: state=WRITE, grant=1<<w, en=1, d=wdata[w], busy=1.
  - wdata is sampled only at this edge.
- WRITE (1 cycle):
  - The flop captures d at the closing edge.
  - At that edge: state=ACK, en=0, ack[w]=1.
  - d holds its value; grant is held.
- ACK (1 cycle):
  - At the closing edge: state=IDLE, ack=0, grant=0, busy=0.
  - ptr=(w+1) mod NUM_REQ.
- Latency:
  - The grant edge is edge k. en is high during cycle k..k+1, and ack is high during cycle k+1..k+2.
  - A new grant is possible at edge k+3, giving a peak throughput of 1 write per 3 cycles.
- req is level-sensitive:
  - A requester must drop req in the cycle after ack, or it is treated as a new request at the next IDLE evaluation.
  - Dropping req during WRITE/ACK does not cancel the transaction; ack is still issued.
- Arbitration boundaries:
  - Simultaneous requests are resolved by the rotating priority only.
  - ptr wraps from NUM_REQ-1 to 0.
  - A single persistent requester is granted every 3 cycles.
  - An idle arbiter never changes ptr.
- Invariants:
  - grant and ack are always zero- or one-hot.
  - ack is a subset of grant.
  - en is never high for two consecutive cycles.

Optional Feature:
- Macro: ARB_WRITE_CHECK_EN.
- With the macro defined:
  - At the ACK closing edge, q_in is compared against the latched d.
  - On mismatch, err is set to 1 and stays set until rst.
- Without the macro: err is tied to 0 and no compare logic is built. The port list is identical in both builds.

Decomposition:
- Package reg_share_pkg holds:
  - the state typedef (IDLE/WRITE/ACK encodings 2'd0/2'd1/2'd2);
  - NUM_REQ_DEFAULT;
  - a function returning the pointer width.
- One sub-module: rr_pick.
  - Combinational rotating-priority encoder.
  - Inputs: req, ptr. Outputs: winner index, valid.
  - Instantiated once.

Test Plan:
- Reset then idle (req=0 for 10 cycles) -> en=0, grant=0, ack=0, busy=0 throughout; ptr stays 0.
- Single write (req=4'b0100, wdata=4'b0100 at edge k):
  - en=1, d=1, grant=4'b0100 after edge k;
  - ack=4'b0100 after edge k+1;
  - q_in=1 during ACK; busy low after edge k+2.
- All four requesting continuously (req=4'b1111) -> grant order 0,1,2,3,0 at edges k, k+3, k+6, k+9, k+12.
- Wrap and fairness (ptr=3, req=4'b1001) -> requester 3 granted first, then requester 0.
- Reset asserted mid-WRITE -> en, grant and busy go to 0 without waiting for a clock edge; no ack pulse; next grant starts from ptr=0.
- ARB_WRITE_CHECK_EN defined, q_in forced 0 after a d=1 write:
  - err=1 after the ACK edge and stays 1 through further good writes;
  - cleared only by rst.
  - Without the macro, err stays 0.
